// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: scoreboard of in-flight writers,
// forwarding selects, load-use stall, redirect flush, event counters.
module pipe_hazard_ctrl #(
    parameter int STAGES     = 3,
    parameter int LOAD_READY = 2,
    parameter int CNT_W      = 32,
    localparam int SELW      = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1_idx,
    input  logic [4:0]       id_rs2_idx,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rd_idx,
    input  logic             id_reg_write,
    input  logic             id_is_load,
    input  logic             redirect_i,
    output logic             enable_o,
    output logic             bubble_e_o,
    output logic             flush_d_o,
    output logic [SELW-1:0]  fwd_rs1_o,
    output logic [SELW-1:0]  fwd_rs2_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic [STAGES:1] sb_valid;
    logic [STAGES:1] sb_load;
    logic [4:0]      sb_rd [1:STAGES];

    logic [SELW-1:0] sel1;
    logic [SELW-1:0] sel2;
    logic            ld1;
    logic            ld2;
    logic            haz;
    logic            stall;
    logic            flush;

    // Youngest matching producer per source; scan oldest first so the
    // smallest stage index overrides.
    always_comb begin
        sel1 = '0;
        sel2 = '0;
        ld1  = 1'b0;
        ld2  = 1'b0;
        for (int k = STAGES; k >= 1; k--) begin
            if (id_rs1_used && id_rs1_idx != 5'd0 && sb_valid[k] &&
                sb_rd[k] == id_rs1_idx) begin
                sel1 = SELW'(k);
                ld1  = sb_load[k];
            end
            if (id_rs2_used && id_rs2_idx != 5'd0 && sb_valid[k] &&
                sb_rd[k] == id_rs2_idx) begin
                sel2 = SELW'(k);
                ld2  = sb_load[k];
            end
        end
    end

    // Stall when a load result is still too young to forward.
    always_comb begin
        haz   = (ld1 && int'(sel1) < LOAD_READY) ||
                (ld2 && int'(sel2) < LOAD_READY);
        stall = ~reset & id_valid & haz;
        flush = ~reset & redirect_i & ~stall;
    end

    assign enable_o   = ~stall;
    assign bubble_e_o = stall;
    assign flush_d_o  = flush;
    assign fwd_rs1_o  = (reset || stall) ? '0 : sel1;
    assign fwd_rs2_o  = (reset || stall) ? '0 : sel2;

    // Scoreboard shift; a stalled ID instruction enters EXE as a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_valid <= '0;
            sb_load  <= '0;
            for (int k = 1; k <= STAGES; k++) begin
                sb_rd[k] <= 5'd0;
            end
        end else begin
            for (int k = STAGES; k >= 2; k--) begin
                sb_valid[k] <= sb_valid[k-1];
                sb_load[k]  <= sb_load[k-1];
                sb_rd[k]    <= sb_rd[k-1];
            end
            sb_valid[1] <= id_valid & id_reg_write &
                           (id_rd_idx != 5'd0) & ~stall;
            sb_load[1]  <= id_is_load;
            sb_rd[1]    <= id_rd_idx;
        end
    end

    // Saturating stall and flush event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall && stall_cnt_o != '1) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
            if (flush && flush_cnt_o != '1) begin
                flush_cnt_o <= flush_cnt_o + 1'b1;
            end
        end
    end

endmodule
